// File: rtl/bkm_bus_pkg.sv
// Shared constants, FSM encoding and command decode for the monitor bus sequencer.
// Command codes, the prepare-block status register, state_t and cmd_ok().
package bkm_bus_pkg;

    localparam logic [7:0] CMD_IRQ         = 8'h02;
    localparam logic [7:0] CMD_INIT        = 8'h10;
    localparam logic [7:0] CMD_ID          = 8'h20;
    localparam logic [7:0] CMD_VIDEO       = 8'h21;
    localparam logic [7:0] CMD_PREPARE     = 8'h22;
    localparam logic [7:0] CMD_SERIAL      = 8'h23;
    localparam logic [7:0] CMD_DESEL       = 8'hFF;
    localparam logic [7:0] PREP_REG_STATUS = 8'h27;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REG    = 2'd1,
        ST_DATA   = 2'd2,
        ST_RDWAIT = 2'd3
    } state_t;

    // Init is gated by the slot line; the rest need the card selected.
    function automatic logic cmd_ok(
        input logic [7:0] c,
        input logic       sel,
        input logic       slot_n
    );
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (c == CMD_INIT):    ok = ~slot_n;
            (c == CMD_IRQ):     ok = sel;
            (c == CMD_ID):      ok = sel;
            (c == CMD_VIDEO):   ok = sel;
            (c == CMD_PREPARE): ok = sel;
            (c == CMD_SERIAL):  ok = sel;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/bkm_bus_sync.sv
// Synchroniser for the bus strobes and data byte, plus clk_rw rising-edge detect.
// Ports: clk, rst_n, raw bus inputs in; rise pulse and aligned synced fields out.
module bkm_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_rw,
    input  logic       ax_d,
    input  logic       r_wx,
    input  logic       slot_x_int_x,
    input  logic [7:0] data_in,
    output logic       rise,
    output logic       ax,
    output logic       rw,
    output logic       slot_n,
    output logic [7:0] din
);

    // Field order: clk_rw, ax_d, r_wx, slot_x_int_x, data_in.
    // Slot select resets to its inactive (high) level.
    localparam logic [11:0] RST = 12'h100;

    logic [SYNC_STAGES-1:0][11:0] pipe;
    logic                         prev;
    logic                         s_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= {SYNC_STAGES{RST}};
            prev <= 1'b0;
        end else begin
            pipe <= {pipe[SYNC_STAGES-2:0],
                     {clk_rw, ax_d, r_wx, slot_x_int_x, data_in}};
            prev <= pipe[SYNC_STAGES-1][11];
        end
    end

    assign {s_clk, ax, rw, slot_n, din} = pipe[SYNC_STAGES-1];
    assign rise = s_clk & ~prev;

endmodule

// File: rtl/bkm_bus_sequencer.sv
// Monitor-bus front-end: frames bus bytes into cmd/reg/data and drives bank txns.
// Ports: bus strobes/data in, data_out/data_oe_x out, wr_valid/rd_req/txn_* to banks,
// rd_ack/rd_data from banks, busy_len for the prepare status sequence (PREP_BUSY_EN).
module bkm_bus_sequencer #(
    parameter int RD_TIMEOUT  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_20mhz,
    input  logic       reset_x,
    input  logic       clk_rw,
    input  logic       ax_d,
    input  logic       r_wx,
    input  logic       slot_x_int_x,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe_x,
    output logic       wr_valid,
    output logic       rd_req,
    output logic [7:0] txn_cmd,
    output logic [7:0] txn_reg,
    output logic [7:0] txn_wdata,
    input  logic       rd_ack,
    input  logic [7:0] rd_data,
    input  logic [7:0] busy_len
);

    import bkm_bus_pkg::*;

    localparam int TW = $clog2(RD_TIMEOUT + 1);

    logic          rise;
    logic          ax;
    logic          rw;
    logic          slot_n;
    logic [7:0]    din;

    state_t        state;
    state_t        state_nx;
    logic          selected;
    logic          rd_done;
    logic [TW-1:0] timer;

    logic          addr_ev;
    logic          data_ev;
    logic          is_ff;
    logic          accept;
    logic          cmd_go;
    logic          dec;
    logic          ack_ok;
    logic          timeout;
    logic          rd_fin;
    logic          prep_sel;

    logic          do_sel;
    logic          do_cmd;
    logic          do_rej;
    logic          do_reg;
    logic          do_wr;
    logic          do_rd;
    logic          do_drop;

    bkm_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk         (clk_20mhz),
        .rst_n       (reset_x),
        .clk_rw      (clk_rw),
        .ax_d        (ax_d),
        .r_wx        (r_wx),
        .slot_x_int_x(slot_x_int_x),
        .data_in     (data_in),
        .rise        (rise),
        .ax          (ax),
        .rw          (rw),
        .slot_n      (slot_n),
        .din         (din)
    );

    assign addr_ev = rise & ~ax;
    assign data_ev = rise & ax;
    assign is_ff   = (din == CMD_DESEL);
    assign accept  = cmd_ok(din, selected, slot_n);
    assign cmd_go  = addr_ev & ~is_ff & accept;
    // In REG the address byte is the register number, not a command.
    assign dec     = addr_ev & (state != ST_REG);
    assign ack_ok  = rd_ack & rd_req;
    assign timeout = rd_req & (timer == TW'(RD_TIMEOUT - 1));
    assign rd_fin  = rd_done | ack_ok | timeout;

`ifdef PREP_BUSY_EN
    logic [7:0] prep_v;
    logic [7:0] busy_cnt;
    logic       prep_hit;

    // Status register of the prepare block is served locally.
    assign prep_sel = (txn_cmd == CMD_PREPARE) && (din == PREP_REG_STATUS);
    assign prep_hit = (txn_cmd == CMD_PREPARE) && (txn_reg == PREP_REG_STATUS);
`else
    logic busy_len_unused;

    assign prep_sel        = 1'b0;
    assign busy_len_unused = ^busy_len;
`endif

    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_go) state_nx = ST_REG;
            end
            ST_REG: begin
                if (addr_ev)      state_nx = ST_DATA;
                else if (data_ev) state_nx = ST_IDLE;
            end
            ST_DATA: begin
                if (addr_ev)
                    state_nx = cmd_go ? ST_REG : ST_IDLE;
                else if (data_ev)
                    state_nx = (rw && !rd_fin) ? ST_RDWAIT : ST_IDLE;
            end
            ST_RDWAIT: begin
                if (addr_ev)     state_nx = cmd_go ? ST_REG : ST_IDLE;
                else if (rd_fin) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        do_sel  = dec & is_ff;
        do_cmd  = dec & cmd_go;
        do_rej  = dec & ~is_ff & ~accept;
        do_reg  = 1'b0;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        do_drop = 1'b0;
        unique case (state)
            ST_IDLE: ;
            ST_REG: begin
                do_reg  = addr_ev;
                do_drop = data_ev;
            end
            ST_DATA: begin
                do_drop = addr_ev;
                do_wr   = data_ev & ~rw;
                do_rd   = data_ev & rw;
            end
            ST_RDWAIT: begin
                do_drop = addr_ev;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x) begin
            data_out  <= 8'hFF;
            wr_valid  <= 1'b0;
            rd_req    <= 1'b0;
            txn_cmd   <= 8'h00;
            txn_reg   <= 8'h00;
            txn_wdata <= 8'h00;
            selected  <= 1'b0;
            rd_done   <= 1'b0;
            timer     <= '0;
`ifdef PREP_BUSY_EN
            prep_v    <= 8'h00;
            busy_cnt  <= 8'h00;
`endif
        end else begin
            wr_valid <= do_wr;
            if (do_sel) selected <= ~selected;
            if (do_cmd) begin
                txn_cmd <= din;
                rd_done <= 1'b0;
            end
            if (do_rej) data_out  <= 8'hFF;
            if (do_wr)  txn_wdata <= din;
            // Prefetch the register as soon as its number is known.
            if (do_reg) begin
                txn_reg <= din;
                rd_req  <= ~prep_sel;
                rd_done <= prep_sel;
                timer   <= '0;
            end else if (rd_req) begin
                if (ack_ok) begin
                    rd_req  <= 1'b0;
                    rd_done <= 1'b1;
                    if (!do_wr) data_out <= rd_data;
                end else if (timeout) begin
                    rd_req   <= 1'b0;
                    rd_done  <= 1'b1;
                    data_out <= 8'hFF;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
            if (do_wr || do_drop) rd_req <= 1'b0;
`ifdef PREP_BUSY_EN
            if (do_wr && prep_hit) begin
                prep_v   <= din;
                busy_cnt <= busy_len;
            end
            if (do_rd && prep_hit) begin
                if (busy_cnt != 8'h00) begin
                    data_out <= prep_v;
                    busy_cnt <= busy_cnt - 8'h01;
                end else begin
                    data_out <= 8'h00;
                    prep_v   <= 8'h00;
                end
            end
`endif
        end
    end

    assign data_oe_x = ~(selected & rw & ax & reset_x);

endmodule

// File: tb/tb_bkm_bus_sequencer.sv
// Scoreboard bench for bkm_bus_sequencer: directed bus frames, queued expectations.
// Write and read-data monitors pop and compare independently of the stimulus.
module tb_bkm_bus_sequencer;

    logic       clk_20mhz = 1'b0;
    logic       reset_x = 1'b0;
    logic       clk_rw = 1'b0;
    logic       ax_d = 1'b0;
    logic       r_wx = 1'b0;
    logic       slot_x_int_x = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe_x;
    logic       wr_valid;
    logic       rd_req;
    logic [7:0] txn_cmd;
    logic [7:0] txn_reg;
    logic [7:0] txn_wdata;
    logic       rd_ack = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] busy_len = 8'h00;

    typedef struct packed {
        logic [7:0] c;
        logic [7:0] r;
        logic [7:0] d;
    } wr_t;

    typedef struct packed {
        logic [7:0] d;
        logic       oe;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];

    int n_tests = 0;
    int n_fail = 0;
    int ack_delay = 0;
    logic [7:0] bank_data = 8'h00;
    int req_run = 0;
    int last_run = 0;
    int req_rises = 0;
    logic rd_req_q = 1'b0;

    bkm_bus_sequencer dut (
        .clk_20mhz   (clk_20mhz),
        .reset_x     (reset_x),
        .clk_rw      (clk_rw),
        .ax_d        (ax_d),
        .r_wx        (r_wx),
        .slot_x_int_x(slot_x_int_x),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe_x   (data_oe_x),
        .wr_valid    (wr_valid),
        .rd_req      (rd_req),
        .txn_cmd     (txn_cmd),
        .txn_reg     (txn_reg),
        .txn_wdata   (txn_wdata),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .busy_len    (busy_len)
    );

    always #5 clk_20mhz = ~clk_20mhz;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic bus_cycle(input logic ax, input logic rw,
                             input logic [7:0] d);
        @(negedge clk_20mhz);
        ax_d = ax;
        r_wx = rw;
        data_in = d;
        repeat (2) @(negedge clk_20mhz);
        clk_rw = 1'b1;
        repeat (10) @(negedge clk_20mhz);
        clk_rw = 1'b0;
        repeat (6) @(negedge clk_20mhz);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] r,
                         input logic rw, input logic [7:0] d);
        bus_cycle(1'b0, rw, c);
        bus_cycle(1'b0, rw, r);
        bus_cycle(1'b1, rw, d);
    endtask

    task automatic exp_wr(input logic [7:0] c, input logic [7:0] r,
                          input logic [7:0] d);
        wr_t w;
        w.c = c;
        w.r = r;
        w.d = d;
        wq.push_back(w);
    endtask

    task automatic exp_rd(input logic [7:0] d, input logic oe);
        rd_t e;
        e.d = d;
        e.oe = oe;
        rq.push_back(e);
    endtask

    // Bank model: acks ack_delay cycles into a request (0 = never).
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk_20mhz);
            rd_ack = 1'b0;
            if (rd_req) begin
                cnt++;
                if (ack_delay > 0 && cnt == ack_delay) begin
                    rd_ack = 1'b1;
                    rd_data = bank_data;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Request length and request-rise bookkeeping.
    initial begin
        forever begin
            @(negedge clk_20mhz);
            if (rd_req) begin
                req_run++;
                if (!rd_req_q) req_rises++;
            end else if (req_run != 0) begin
                last_run = req_run;
                req_run = 0;
            end
            rd_req_q = rd_req;
        end
    end

    // Write monitor.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk_20mhz);
            if (wr_valid) begin
                if (wq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got cmd %02h reg %02h wdata %02h expected no write",
                             txn_cmd, txn_reg, txn_wdata);
                end else begin
                    w = wq.pop_front();
                    chk("wr_cmd", txn_cmd, w.c);
                    chk("wr_reg", txn_reg, w.r);
                    chk("wr_wdata", txn_wdata, w.d);
                end
            end
        end
    end

    // Read-data monitor: samples what the bus master sees at strobe end.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk_rw);
            if (ax_d && r_wx) begin
                if (rq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got %02h expected no read", data_out);
                end else begin
                    e = rq.pop_front();
                    chk("rd_data", data_out, e.d);
                    chk("rd_oe_x", {7'd0, data_oe_x}, {7'd0, e.oe});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rises0;
        repeat (3) @(negedge clk_20mhz);
        chk("rst_data_out", data_out, 8'hFF);
        chk("rst_oe_x", {7'd0, data_oe_x}, 8'h01);
        chk("rst_wr_valid", {7'd0, wr_valid}, 8'h00);
        chk("rst_rd_req", {7'd0, rd_req}, 8'h00);
        chk("rst_txn_cmd", txn_cmd, 8'h00);
        chk("rst_txn_reg", txn_reg, 8'h00);
        reset_x = 1'b1;
        repeat (4) @(negedge clk_20mhz);

        // Init with slot deselected: rejected, no write.
        slot_x_int_x = 1'b1;
        frame(8'h10, 8'h41, 1'b0, 8'h02);
        chk("slot_hi_data_out", data_out, 8'hFF);

        // Init with slot selected.
        slot_x_int_x = 1'b0;
        exp_wr(8'h10, 8'h41, 8'h02);
        frame(8'h10, 8'h41, 1'b0, 8'h02);

        // Select, then prepare write.
        bus_cycle(1'b0, 1'b0, 8'hFF);
        exp_wr(8'h22, 8'h26, 8'h01);
        frame(8'h22, 8'h26, 1'b0, 8'h01);
        chk("wr_rd_req_low", {7'd0, rd_req}, 8'h00);

        // Read with ack after 3 cycles.
        ack_delay = 3;
        bank_data = 8'h88;
        exp_rd(8'h88, 1'b0);
        frame(8'h20, 8'h00, 1'b1, 8'h00);

        // Read with no ack: timeout.
        ack_delay = 0;
        exp_rd(8'hFF, 1'b0);
        frame(8'h21, 8'h31, 1'b1, 8'h00);
        chk("timeout_len", last_run[7:0], 8'd8);

        // Address byte in DATA aborts and starts a new frame.
        bus_cycle(1'b0, 1'b0, 8'h20);
        bus_cycle(1'b0, 1'b0, 8'h05);
        exp_wr(8'h21, 8'h31, 8'h44);
        frame(8'h21, 8'h31, 1'b0, 8'h44);

`ifdef PREP_BUSY_EN
        rises0 = req_rises;
        busy_len = 8'd3;
        exp_wr(8'h22, 8'h27, 8'h09);
        frame(8'h22, 8'h27, 1'b0, 8'h09);
        exp_rd(8'h09, 1'b0);
        exp_rd(8'h09, 1'b0);
        exp_rd(8'h09, 1'b0);
        exp_rd(8'h00, 1'b0);
        exp_rd(8'h00, 1'b0);
        repeat (5) frame(8'h22, 8'h27, 1'b1, 8'h00);
        n = req_rises - rises0;
        chk("prep_no_rd_req", n[7:0], 8'h00);
        busy_len = 8'd0;
        exp_wr(8'h22, 8'h27, 8'h07);
        frame(8'h22, 8'h27, 1'b0, 8'h07);
        exp_rd(8'h00, 1'b0);
        frame(8'h22, 8'h27, 1'b1, 8'h00);
        busy_len = 8'd2;
        exp_wr(8'h22, 8'h27, 8'h0A);
        frame(8'h22, 8'h27, 1'b0, 8'h0A);
        exp_rd(8'h0A, 1'b0);
        frame(8'h22, 8'h27, 1'b1, 8'h00);
        exp_wr(8'h22, 8'h27, 8'h0B);
        frame(8'h22, 8'h27, 1'b0, 8'h0B);
        exp_rd(8'h0B, 1'b0);
        exp_rd(8'h0B, 1'b0);
        exp_rd(8'h00, 1'b0);
        repeat (3) frame(8'h22, 8'h27, 1'b1, 8'h00);
`else
        rises0 = req_rises;
        ack_delay = 2;
        bank_data = 8'h5A;
        exp_rd(8'h5A, 1'b0);
        frame(8'h22, 8'h27, 1'b1, 8'h00);
        n = req_rises - rises0;
        chk("reg27_rd_req", n[7:0], 8'h01);
`endif

        // Reset in the middle of a read frame, while DATA has rd_req high.
        ack_delay = 0;
`ifdef PREP_BUSY_EN
        chk("pre_rst_data_out", data_out, 8'h00);
`else
        chk("pre_rst_data_out", data_out, 8'h5A);
`endif
        bus_cycle(1'b0, 1'b1, 8'h20);
        @(negedge clk_20mhz);
        ax_d = 1'b0;
        data_in = 8'h00;
        @(negedge clk_20mhz);
        clk_rw = 1'b1;
        repeat (5) @(negedge clk_20mhz);
        chk("mid_rd_req", {7'd0, rd_req}, 8'h01);
        #3;
        reset_x = 1'b0;
        #1;
        chk("arst_data_out", data_out, 8'hFF);
        chk("arst_oe_x", {7'd0, data_oe_x}, 8'h01);
        chk("arst_rd_req", {7'd0, rd_req}, 8'h00);
        @(negedge clk_20mhz);
        clk_rw = 1'b0;
        repeat (4) @(negedge clk_20mhz);
        reset_x = 1'b1;
        repeat (4) @(negedge clk_20mhz);

        // Selection is cleared: id read is rejected and not driven.
        exp_rd(8'hFF, 1'b1);
        frame(8'h20, 8'h00, 1'b1, 8'h00);
        exp_wr(8'h10, 8'h41, 8'h03);
        frame(8'h10, 8'h41, 1'b0, 8'h03);

        repeat (20) @(negedge clk_20mhz);
        n = wq.size();
        chk("wq_left", n[7:0], 8'h00);
        n = rq.size();
        chk("rq_left", n[7:0], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
